// File: rtl/up_counter_target_if.sv
// Bundle of the control and status signals for up_counter_target.
// Ports:
//   start, clear, en, target : control, driven by the master
//   count, busy, paused, done, tc : status, driven by the counter (slave)
interface up_counter_target_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic             clear;
    logic             en;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             done;
    logic             tc;

    modport master (
        output start, clear, en, target,
        input  count, busy, paused, done, tc
    );

    modport slave (
        input  start, clear, en, target,
        output count, busy, paused, done, tc
    );
endinterface

// File: rtl/up_counter_target.sv
// Loadable up-counter: counts from 0 to a captured target and flags completion,
// with run/pause/done tracking and an optional auto-reload (wrap to 0) mode.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : up_counter_target_if.slave
//          start  - capture target and restart from 0
//          clear  - return to IDLE with count 0
//          en     - count enable, low pauses an active count
//          target - terminal value, sampled only on an accepted start
//          count  - current count
//          busy   - RUN or PAUSE
//          paused - PAUSE
//          done   - DONE (never reached with auto-reload)
//          tc     - one-cycle pulse on the edge count reaches the target
// Edge priority: rst > clear > start > en.
module up_counter_target #(
    parameter int WIDTH       = 6,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    up_counter_target_if.slave bus
);
    localparam bit               AR  = (AUTO_RELOAD != 0);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] target_q;
    logic             busy_q;
    logic             paused_q;
    logic             done_q;
    logic             tc_q;

    logic [WIDTH-1:0] step_cnt;
    logic             step_hit;

    // Without auto-reload an active count is always below target_q, so the
    // increment cannot overflow. With auto-reload the count sits on target_q
    // for one enabled edge and then wraps to 0.
    always_comb begin
        step_cnt = count_q + ONE;
        if (AR && (count_q == target_q)) begin
            step_cnt = '0;
        end
        step_hit = (step_cnt == target_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            count_q  <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (bus.clear) begin
                state    <= S_IDLE;
                count_q  <= '0;
                busy_q   <= 1'b0;
                paused_q <= 1'b0;
                done_q   <= 1'b0;
            end else if (bus.start) begin
                target_q <= bus.target;
                count_q  <= '0;
                paused_q <= 1'b0;
                // A zero target is reached on the start edge itself.
                if (bus.target == '0) begin
                    tc_q <= 1'b1;
                end
                if ((bus.target == '0) && !AR) begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    state  <= S_RUN;
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                end
            end else begin
                case (state)
                    S_RUN, S_PAUSE: begin
                        if (bus.en) begin
                            // Resuming from PAUSE counts on the same edge.
                            count_q  <= step_cnt;
                            paused_q <= 1'b0;
                            state    <= S_RUN;
                            if (step_hit) begin
                                tc_q <= 1'b1;
                                if (!AR) begin
                                    state  <= S_DONE;
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end
                            end
                        end else begin
                            state    <= S_PAUSE;
                            paused_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.count  = count_q;
    assign bus.busy   = busy_q;
    assign bus.paused = paused_q;
    assign bus.done   = done_q;
    assign bus.tc     = tc_q;
endmodule

// File: tb/tb_up_counter_target.sv
module tb_up_counter_target;
    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start;
    logic         clear;
    logic         en;
    logic [W-1:0] target;

    up_counter_target_if #(.WIDTH(W)) bus0 ();
    up_counter_target_if #(.WIDTH(W)) bus1 ();

    assign bus0.start  = start;
    assign bus0.clear  = clear;
    assign bus0.en     = en;
    assign bus0.target = target;
    assign bus1.start  = start;
    assign bus1.clear  = clear;
    assign bus1.en     = en;
    assign bus1.target = target;

    up_counter_target #(.WIDTH(W), .AUTO_RELOAD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    up_counter_target #(.WIDTH(W), .AUTO_RELOAD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: counts enabled steps since the last start and derives
    // the count from that (saturating at the target, or modulo target+1).
    bit m_active[2];
    bit m_held[2];
    bit m_fin[2];
    bit m_tc[2];
    int m_steps[2];
    int m_tgt[2];

    function automatic int mdl_count(input int i);
        if (i == 1) return m_steps[i] % (m_tgt[i] + 1);
        return (m_steps[i] < m_tgt[i]) ? m_steps[i] : m_tgt[i];
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_held[i] = 0; m_fin[i] = 0; m_tc[i] = 0;
            m_steps[i] = 0;  m_tgt[i] = 0;
        end
    endfunction

    function automatic void mdl_step(input int i);
        bit ar;
        ar = (i == 1);
        m_tc[i] = 0;
        if (clear) begin
            m_active[i] = 0; m_held[i] = 0; m_fin[i] = 0; m_steps[i] = 0;
        end else if (start) begin
            m_tgt[i]   = int'(target);
            m_steps[i] = 0;
            m_held[i]  = 0;
            m_tc[i]    = (m_tgt[i] == 0);
            m_fin[i]   = (m_tgt[i] == 0) && !ar;
            m_active[i] = !m_fin[i];
        end else if (m_active[i] && en) begin
            m_steps[i]++;
            m_held[i] = 0;
            m_tc[i] = ar ? ((m_steps[i] % (m_tgt[i] + 1)) == m_tgt[i])
                         : (m_steps[i] == m_tgt[i]);
            if (!ar && m_steps[i] == m_tgt[i]) begin
                m_fin[i] = 1; m_active[i] = 0;
            end
        end else if (m_active[i]) begin
            m_held[i] = 1;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".a0.count"},  int'(bus0.count),  mdl_count(0));
        chk({tag, ".a0.busy"},   int'(bus0.busy),   int'(m_active[0]));
        chk({tag, ".a0.paused"}, int'(bus0.paused), int'(m_held[0]));
        chk({tag, ".a0.done"},   int'(bus0.done),   int'(m_fin[0]));
        chk({tag, ".a0.tc"},     int'(bus0.tc),     int'(m_tc[0]));
        chk({tag, ".a1.count"},  int'(bus1.count),  mdl_count(1));
        chk({tag, ".a1.busy"},   int'(bus1.busy),   int'(m_active[1]));
        chk({tag, ".a1.paused"}, int'(bus1.paused), int'(m_held[1]));
        chk({tag, ".a1.done"},   int'(bus1.done),   int'(m_fin[1]));
        chk({tag, ".a1.tc"},     int'(bus1.tc),     int'(m_tc[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) mdl_reset();
        else begin
            mdl_step(0);
            mdl_step(1);
        end
        #1;
        check_all("cyc");
    endtask

    initial begin
        int tcs;
        start = 0; clear = 0; en = 0; target = '0;
        mdl_reset();
        #5;
        check_all("reset");
        repeat (2) cycle();
        @(negedge clk);
        rst = 0;

        // Full run to 43, tc exactly once, done held.
        target = 6'd43; start = 1; en = 1;
        cycle();
        start = 0; target = 6'd5;
        tcs = 0;
        repeat (43) begin
            cycle();
            tcs += int'(bus0.tc);
        end
        chk("t43_count", int'(bus0.count), 43);
        chk("t43_done", int'(bus0.done), 1);
        chk("t43_tc_pulses", tcs, 1);
        repeat (3) cycle();
        chk("t43_hold", int'(bus0.count), 43);

        // Pause at 10 for 3 cycles, resume.
        target = 6'd30; start = 1;
        cycle();
        start = 0;
        repeat (10) cycle();
        chk("pause_pre", int'(bus0.count), 10);
        en = 0;
        repeat (3) cycle();
        chk("pause_count", int'(bus0.count), 10);
        chk("pause_paused", int'(bus0.paused), 1);
        chk("pause_busy", int'(bus0.busy), 1);
        en = 1;
        cycle();
        chk("resume_count", int'(bus0.count), 11);

        // Restart mid-run at 20 with target 6.
        repeat (9) cycle();
        chk("restart_pre", int'(bus0.count), 20);
        target = 6'd6; start = 1;
        cycle();
        start = 0;
        chk("restart_count", int'(bus0.count), 0);
        chk("restart_tc", int'(bus0.tc), 0);
        repeat (6) cycle();
        chk("restart_end", int'(bus0.count), 6);
        chk("restart_done", int'(bus0.done), 1);

        // Zero target, then clear.
        target = 6'd0; start = 1;
        cycle();
        start = 0;
        chk("zero_done", int'(bus0.done), 1);
        chk("zero_tc", int'(bus0.tc), 1);
        cycle();
        chk("zero_tc_gone", int'(bus0.tc), 0);
        clear = 1;
        cycle();
        clear = 0;
        chk("clear_done", int'(bus0.done), 0);

        // Auto-reload with target 3: tc on steps 3, 7, 11.
        target = 6'd3; start = 1;
        cycle();
        start = 0;
        tcs = 0;
        repeat (12) begin
            cycle();
            tcs += int'(bus1.tc);
        end
        chk("ar3_tc_pulses", tcs, 3);

        // Full-scale target.
        target = 6'd63; start = 1;
        cycle();
        start = 0;
        repeat (63) cycle();
        chk("t63_a0", int'(bus0.count), 63);
        chk("t63_a1", int'(bus1.count), 63);
        cycle();
        chk("t63_a1_wrap", int'(bus1.count), 0);
        chk("t63_a0_hold", int'(bus0.count), 63);

        // Asynchronous reset mid-run at count 17.
        target = 6'd40; start = 1;
        cycle();
        start = 0;
        repeat (17) cycle();
        chk("arst_pre", int'(bus0.count), 17);
        #5 rst = 1;
        #1;
        mdl_reset();
        check_all("arst");
        chk("arst_count", int'(bus0.count), 0);
        @(negedge clk);
        rst = 0;

        // Randomized traffic.
        repeat (3000) begin
            start  = ($urandom_range(0, 99) < 6);
            clear  = ($urandom_range(0, 99) < 2);
            en     = ($urandom_range(0, 99) < 80);
            target = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3))
                                                 : W'($urandom_range(0, 63));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
